osd_spi_tx: RTL



---
 rtl/osd_spi_pkg.sv | 25 ++
 rtl/osd_spi_tx_fifo.sv | 66 ++++++
 rtl/osd_spi_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/osd_spi_pkg.sv
// ============================================================================
// Module      : osd_spi_pkg
// Description : Shared FSM state encoding and default timing constants for
//               the OSD SPI transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package osd_spi_pkg;

  localparam int unsigned SCK_DIV_DEFAULT = 4;
  localparam int unsigned CS_GAP_DEFAULT  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    STALL    = 3'd3,
    END_HOLD = 3'd4,
    GAP      = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/osd_spi_tx_fifo.sv
// ============================================================================
// Module      : osd_spi_tx_fifo
// Description : 4-entry byte FIFO (data plus frame-last flag) feeding the
//               OSD SPI shifter; used only when OSD_SPI_TX_FIFO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osd_spi_tx_fifo (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic       valid,
  output logic [7:0] data,
  output logic       last,
  output logic       full
);

  logic [8:0] mem_q [4];
  logic [8:0] mem_d [4];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full    = (cnt_q == 3'd4);
  assign valid   = (cnt_q != 3'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign data    = mem_q[rptr_q][7:0];
  assign last    = mem_q[rptr_q][8];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + {2'b00, do_push} - {2'b00, do_pop};
    if (do_push) begin
      mem_d[wptr_q] = {push_last, push_data};
      wptr_d        = wptr_q + 2'd1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/osd_spi_tx.sv
// ============================================================================
// Module      : osd_spi_tx
// Description : OSD SPI link transmitter, MSB first, SCK idle low, SS3 active
//               low. Define OSD_SPI_TX_FIFO_EN for a 4-deep input FIFO instead
//               of the single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module osd_spi_tx
  import osd_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV = SCK_DIV_DEFAULT,
  parameter int unsigned CS_GAP  = CS_GAP_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  localparam logic [7:0] c_half_reload = 8'(SCK_DIV - 1);
  localparam logic [7:0] c_gap_reload  = 8'(CS_GAP - 1);

  logic       push;
  logic       buf_valid, buf_last, buf_pop;
  logic [7:0] buf_data;

  assign push = tx_valid & tx_ready;

`ifdef OSD_SPI_TX_FIFO_EN
  logic buf_full;

  osd_spi_tx_fifo u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (tx_data),
    .push_last (tx_last),
    .pop       (buf_pop),
    .valid     (buf_valid),
    .data      (buf_data),
    .last      (buf_last),
    .full      (buf_full)
  );

  assign tx_ready = ~buf_full;
`else
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic       hold_last_q, hold_last_d;

  // tx_ready is ~hold_valid, so a push and a pop never meet in one cycle.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    if (buf_pop) begin
      hold_valid_d = 1'b0;
    end
    if (push) begin
      hold_valid_d = 1'b1;
      hold_data_d  = tx_data;
      hold_last_d  = tx_last;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
    end
  end

  assign buf_valid = hold_valid_q;
  assign buf_data  = hold_data_q;
  assign buf_last  = hold_last_q;
  assign tx_ready  = ~hold_valid_q;
`endif

  state_e     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_q, last_d;
  logic       sck_q, sck_d;
  logic       ss3_q, ss3_d;
  logic       load;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    sck_d    = sck_q;
    ss3_d    = ss3_q;
    load     = 1'b0;

    unique case (state_q)
      IDLE:     load = buf_valid;
      SHIFT_LO: begin
        if (hcnt_q == 8'd0) begin
          sck_d   = 1'b1;
          hcnt_d  = c_half_reload;
          state_d = SHIFT_HI;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      SHIFT_HI: begin
        if (hcnt_q == 8'd0) begin
          sck_d    = 1'b0;
          bitcnt_d = bitcnt_q + 3'd1;
          hcnt_d   = c_half_reload;
          // After bit 0 the shifter is left alone so DI holds through STALL/END_HOLD.
          if (bitcnt_q != 3'd7) begin
            shreg_d = {shreg_q[6:0], 1'b0};
            state_d = SHIFT_LO;
          end else if (last_q) begin
            state_d = END_HOLD;
          end else if (buf_valid) begin
            load = 1'b1;
          end else begin
            state_d = STALL;
          end
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      STALL:    load = buf_valid;
      END_HOLD: begin
        if (hcnt_q == 8'd0) begin
          ss3_d   = 1'b1;
          hcnt_d  = c_gap_reload;
          state_d = GAP;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      GAP: begin
        if (hcnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      default:  state_d = IDLE;
    endcase

    if (load) begin
      shreg_d  = buf_data;
      last_d   = buf_last;
      hcnt_d   = c_half_reload;
      bitcnt_d = 3'd0;
      sck_d    = 1'b0;
      ss3_d    = 1'b0;
      state_d  = SHIFT_LO;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      last_q   <= 1'b0;
      sck_q    <= 1'b0;
      ss3_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      sck_q    <= sck_d;
      ss3_q    <= ss3_d;
    end
  end

  assign buf_pop = load;
  assign busy    = (state_q != IDLE);
  assign SPI_SCK = sck_q;
  assign SPI_SS3 = ss3_q;
  assign SPI_DI  = shreg_q[7];

endmodule

`default_nettype wire
